// File: rtl/i3c_phy_pkg.sv
// rtl/i3c_phy_pkg.sv - shared types and default constants for the I3C PHY receive path
//
// Contents:
//   bus_state_e        - bus-state FSM encoding (WAIT_IDLE, FREE, BUSY)
//   SyncStagesDefault  - default synchronizer depth
//   FiltCntWDefault    - default glitch-filter counter width
//   IdleCntWDefault    - default bus-idle counter width
package i3c_phy_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    FREE      = 2'd1,
    BUSY      = 2'd2
  } bus_state_e;

  localparam int SyncStagesDefault = 2;
  localparam int FiltCntWDefault   = 4;
  localparam int IdleCntWDefault   = 16;

endpackage

// File: rtl/bus_rx_sampler_if.sv
// rtl/bus_rx_sampler_if.sv - pad, configuration and event signals of the receive sampler
//
// Signals:
//   scl_i, sda_i           raw pad levels (asynchronous)
//   t_filt_i, t_idle_i     glitch-filter length / bus-free time in cycles (quasi-static)
//   scl_o, sda_o           filtered line levels
//   scl_posedge_o ...      one-cycle edge strobes on the filtered lines
//   start_det_o/stop_det_o one-cycle START / STOP strobes
//   bus_free_o             bus idle and free time elapsed
// Modports:
//   master - pad/config driver, consumes the events
//   slave  - the sampler itself
interface bus_rx_sampler_if
  import i3c_phy_pkg::*;
#(
  parameter int FiltCntW = FiltCntWDefault,
  parameter int IdleCntW = IdleCntWDefault
);

  logic                scl_i;
  logic                sda_i;
  logic [FiltCntW-1:0] t_filt_i;
  logic [IdleCntW-1:0] t_idle_i;
  logic                scl_o;
  logic                sda_o;
  logic                scl_posedge_o;
  logic                scl_negedge_o;
  logic                sda_posedge_o;
  logic                sda_negedge_o;
  logic                start_det_o;
  logic                stop_det_o;
  logic                bus_free_o;

  modport master (
    output scl_i, sda_i, t_filt_i, t_idle_i,
    input  scl_o, sda_o, scl_posedge_o, scl_negedge_o,
    input  sda_posedge_o, sda_negedge_o, start_det_o, stop_det_o, bus_free_o
  );

  modport slave (
    input  scl_i, sda_i, t_filt_i, t_idle_i,
    output scl_o, sda_o, scl_posedge_o, scl_negedge_o,
    output sda_posedge_o, sda_negedge_o, start_det_o, stop_det_o, bus_free_o
  );

endinterface

// File: rtl/line_filter.sv
// rtl/line_filter.sv - per-line synchronizer, glitch filter and edge strobes
//
// Optional feature macro: I3C_RX_GLITCH_FILTER_EN (filter counter present when defined;
// otherwise the filtered level is one register stage after the synchronizer).
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   pad_i           raw asynchronous pad level
//   t_filt_i        qualification length in cycles (0 = one-cycle qualification)
//   level_o         filtered level (reset 1)
//   level_nxt_o     value level_o takes at the next edge, for aligned downstream registers
//   rise_o, fall_o  registered strobes, high in the first cycle level_o shows the new value
module line_filter #(
  parameter int SyncStages = 2,
  parameter int FiltCntW   = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pad_i,
  input  logic [FiltCntW-1:0] t_filt_i,
  output logic                level_o,
  output logic                level_nxt_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_lvl;
  logic                  level_q;
  logic                  level_nxt;
  logic                  rise_q;
  logic                  fall_q;

  // Synchronizer resets to 1 so reset release looks like an idle bus.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_i};
    end
  end

  assign sync_lvl = sync_q[SyncStages-1];

`ifdef I3C_RX_GLITCH_FILTER_EN
  logic [FiltCntW-1:0] cnt_q;
  logic [FiltCntW-1:0] cnt_nxt;

  // The counter measures how long the synchronized level has disagreed with
  // the filtered one; agreement at any point restarts qualification.
  always_comb begin
    level_nxt = level_q;
    cnt_nxt   = cnt_q;
    if (sync_lvl == level_q) begin
      cnt_nxt = '0;
    end else if (cnt_q == t_filt_i) begin
      level_nxt = sync_lvl;
      cnt_nxt   = '0;
    end else begin
      cnt_nxt = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_nxt;
    end
  end
`else
  logic unused_t_filt;

  assign unused_t_filt = ^t_filt_i;
  assign level_nxt     = sync_lvl;
`endif

  // Strobes are registered with the level so they line up with level_o.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_nxt;
      rise_q  <= level_nxt & ~level_q;
      fall_q  <= ~level_nxt & level_q;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_nxt;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;

endmodule

// File: rtl/bus_rx_sampler.sv
// rtl/bus_rx_sampler.sv - I3C receive front end: clean levels, edges, START/STOP, bus-free
//
// Optional feature macro: I3C_RX_GLITCH_FILTER_EN (forwarded to line_filter).
//
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     bus_rx_sampler_if.slave: pads, t_filt_i/t_idle_i, filtered levels,
//           edge strobes, start_det_o/stop_det_o, bus_free_o
module bus_rx_sampler
  import i3c_phy_pkg::*;
#(
  parameter int SyncStages = SyncStagesDefault,
  parameter int FiltCntW   = FiltCntWDefault,
  parameter int IdleCntW   = IdleCntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  bus_rx_sampler_if.slave  bus
);

  logic                scl_lvl, scl_nxt, scl_rise, scl_fall;
  logic                sda_lvl, sda_nxt, sda_rise, sda_fall;
  logic [FiltCntW-1:0] t_filt;
  logic [IdleCntW-1:0] t_idle;
  logic                start_nxt;
  logic                stop_nxt;
  logic                lines_high_nxt;
  logic [IdleCntW-1:0] idle_cnt_q;
  logic [IdleCntW-1:0] idle_cnt_nxt;
  bus_state_e          state_q;
  logic                start_q;
  logic                stop_q;
  logic                bus_free_q;

  assign t_filt = bus.t_filt_i;
  assign t_idle = bus.t_idle_i;

  line_filter #(
    .SyncStages (SyncStages),
    .FiltCntW   (FiltCntW)
  ) u_scl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pad_i       (bus.scl_i),
    .t_filt_i    (t_filt),
    .level_o     (scl_lvl),
    .level_nxt_o (scl_nxt),
    .rise_o      (scl_rise),
    .fall_o      (scl_fall)
  );

  line_filter #(
    .SyncStages (SyncStages),
    .FiltCntW   (FiltCntW)
  ) u_sda (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pad_i       (bus.sda_i),
    .t_filt_i    (t_filt),
    .level_o     (sda_lvl),
    .level_nxt_o (sda_nxt),
    .rise_o      (sda_rise),
    .fall_o      (sda_fall)
  );

  // Decisions use the levels the filters are about to present, so every
  // registered output here lands in the same cycle as the SDA edge strobe.
  // Requiring SCL high both now and next excludes simultaneous SCL/SDA changes.
  assign start_nxt      = scl_lvl & scl_nxt & sda_lvl & ~sda_nxt;
  assign stop_nxt       = scl_lvl & scl_nxt & ~sda_lvl & sda_nxt;
  assign lines_high_nxt = scl_nxt & sda_nxt;

  // STOP forces 0 so the bus-free time is measured from the STOP cycle.
  always_comb begin
    idle_cnt_nxt = idle_cnt_q;
    if (!lines_high_nxt || stop_nxt) begin
      idle_cnt_nxt = '0;
    end else if (idle_cnt_q >= t_idle) begin
      idle_cnt_nxt = t_idle;
    end else begin
      idle_cnt_nxt = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= WAIT_IDLE;
      idle_cnt_q <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      bus_free_q <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_nxt;
      start_q    <= start_nxt;
      stop_q     <= stop_nxt;
      case (state_q)
        WAIT_IDLE: begin
          if (start_nxt) begin
            state_q    <= BUSY;
            bus_free_q <= 1'b0;
          end else if ((idle_cnt_q >= t_idle) && lines_high_nxt) begin
            state_q    <= FREE;
            bus_free_q <= 1'b1;
          end
        end
        FREE: begin
          if (start_nxt || !lines_high_nxt) begin
            state_q    <= BUSY;
            bus_free_q <= 1'b0;
          end
        end
        BUSY: begin
          // A START seen here is a repeated START: strobe only, no state change.
          if (stop_nxt) begin
            state_q <= WAIT_IDLE;
          end
        end
        default: begin
          state_q    <= WAIT_IDLE;
          bus_free_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.scl_o         = scl_lvl;
  assign bus.sda_o         = sda_lvl;
  assign bus.scl_posedge_o = scl_rise;
  assign bus.scl_negedge_o = scl_fall;
  assign bus.sda_posedge_o = sda_rise;
  assign bus.sda_negedge_o = sda_fall;
  assign bus.start_det_o   = start_q;
  assign bus.stop_det_o    = stop_q;
  assign bus.bus_free_o    = bus_free_q;

endmodule
